// File: rtl/arb_mux_21_pkg.sv
// -----------------------------------------------------------------------------
// arb_mux_21_pkg
// Shared definitions for the arb_mux_21 arbiter/sequencer:
//   state_t       FSM state codes (IDLE / OWN0 / OWN1)
//   SEL_IN1/2     mux select codes (0 -> in1, 1 -> in2)
//   own_state()   ownership state for requester index 0/1
//   sel_of()      mux select code for requester index 0/1
// -----------------------------------------------------------------------------
package arb_mux_21_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   localparam logic SEL_IN1 = 1'b0;
   localparam logic SEL_IN2 = 1'b1;

   // Requester index (0/1) -> state that gives that requester ownership.
   function automatic state_t own_state(input logic side);
      return side ? ST_OWN1 : ST_OWN0;
   endfunction

   // Requester index (0/1) -> mux select routing that requester's data.
   function automatic logic sel_of(input logic side);
      return side ? SEL_IN2 : SEL_IN1;
   endfunction

endpackage : arb_mux_21_pkg

// File: rtl/arb_out_reg.sv
// -----------------------------------------------------------------------------
// arb_out_reg
// One-entry registered valid/ready output stage.
//   clk, rst    clock, asynchronous active-high reset
//   load        capture d into y this cycle (caller guarantees space)
//   d           data to capture
//   out_ready   downstream consumer accepts y when out_valid & out_ready
//   out_valid   y holds an unconsumed beat
//   y           registered output data
//   space       register can accept a load this cycle
// -----------------------------------------------------------------------------
module arb_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] y,
   output logic             space
);

   // Empty, or the current beat leaves this cycle: a load can replace it.
   assign space = !out_valid | out_ready;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
      end else if (load) begin
         y         <= d;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule : arb_out_reg

// File: rtl/arb_mux_21.sv
// -----------------------------------------------------------------------------
// arb_mux_21
// Round-robin arbiter/sequencer sharing one WIDTH-bit 2:1 datapath between two
// requesters, with burst-length bounding and a registered valid/ready output.
//   clk, rst     clock, asynchronous active-high reset
//   req0, in1    requester 0 beat request and data
//   req1, in2    requester 1 beat request and data
//   gnt0, gnt1   beat from requester K accepted when reqK & gntK
//   select       registered mux select (0 -> in1, 1 -> in2)
//   out_valid    y holds an unconsumed beat
//   out_ready    consumer accepts y when out_valid & out_ready
//   y            registered output data
// -----------------------------------------------------------------------------
module arb_mux_21
   import arb_mux_21_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] in1,
   input  logic             req1,
   input  logic [WIDTH-1:0] in2,
   output logic             gnt0,
   output logic             gnt1,
   output logic             select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last;      // requester left at the most recent handover
   logic             space;
   logic             own_id;
   logic             own_req;
   logic             own_gnt;
   logic             other_req;
   logic             beat;
   logic             burst_end;

   // Grants come straight from registered state plus output-stage space.
   assign gnt0 = (state == ST_OWN0) & space;
   assign gnt1 = (state == ST_OWN1) & space;

   // Owner-relative view of the request/grant pair, so the FSM handles OWN0
   // and OWN1 with one body.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      own_id    = 1'b0;
      own_req   = 1'b0;
      own_gnt   = 1'b0;
      other_req = 1'b0;
      case (state)
         ST_OWN0: begin
            own_id    = 1'b0;
            own_req   = req0;
            own_gnt   = gnt0;
            other_req = req1;
         end
         ST_OWN1: begin
            own_id    = 1'b1;
            own_req   = req1;
            own_gnt   = gnt1;
            other_req = req0;
         end
         default: ;
      endcase
   end

   assign beat      = own_req & own_gnt;
   assign burst_end = (cnt == CNT_W'(MAX_BURST - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         last   <= 1'b1;          // requester 0 wins the first tie
         select <= SEL_IN1;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (req0 && req1) begin
                  state  <= own_state(!last);
                  select <= sel_of(!last);
               end else if (req0) begin
                  state  <= ST_OWN0;
                  select <= SEL_IN1;
               end else if (req1) begin
                  state  <= ST_OWN1;
                  select <= SEL_IN2;
               end
            end

            ST_OWN0, ST_OWN1: begin
               if (!own_req) begin
                  // Owner went quiet: hand over if the other side waits,
                  // otherwise park in IDLE keeping the tie-break history.
                  cnt <= '0;
                  if (other_req) begin
                     state  <= own_state(!own_id);
                     select <= sel_of(!own_id);
                     last   <= own_id;
                  end else begin
                     state  <= ST_IDLE;
                     select <= SEL_IN1;
                  end
               end else if (beat) begin
                  if (burst_end) begin
                     // Burst limit reached: yield only if someone is waiting.
                     cnt <= '0;
                     if (other_req) begin
                        state  <= own_state(!own_id);
                        select <= sel_of(!own_id);
                        last   <= own_id;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               // Stalled (no space): state and count hold.
            end

            default: begin
               state  <= ST_IDLE;
               select <= SEL_IN1;
               cnt    <= '0;
            end
         endcase
      end
   end

   arb_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (beat),
      .d         ((select == SEL_IN2) ? in2 : in1),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .y         (y),
      .space     (space)
   );

endmodule : arb_mux_21

// File: tb/tb_arb_mux_21.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_21
// Directed bench for arb_mux_21. Instance a uses MAX_BURST=4, instance b uses
// MAX_BURST=1; both share clock and reset. Inputs change 1 time unit after the
// rising edge, outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_arb_mux_21;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;

   logic             a_req0, a_req1, a_out_ready;
   logic [WIDTH-1:0] a_in1, a_in2, a_y;
   logic             a_gnt0, a_gnt1, a_select, a_out_valid;

   logic             b_req0, b_req1, b_out_ready;
   logic [WIDTH-1:0] b_in1, b_in2, b_y;
   logic             b_gnt0, b_gnt1, b_select, b_out_valid;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   arb_mux_21 #(.WIDTH(WIDTH), .MAX_BURST(4)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .req0      (a_req0),
      .in1       (a_in1),
      .req1      (a_req1),
      .in2       (a_in2),
      .gnt0      (a_gnt0),
      .gnt1      (a_gnt1),
      .select    (a_select),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .y         (a_y)
   );

   arb_mux_21 #(.WIDTH(WIDTH), .MAX_BURST(1)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .req0      (b_req0),
      .in1       (b_in1),
      .req1      (b_req1),
      .in2       (b_in2),
      .gnt0      (b_gnt0),
      .gnt1      (b_gnt1),
      .select    (b_select),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .y         (b_y)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] own_seq;
      logic       exp_side;

      rst = 1'b1;
      a_req0 = 1'b0; a_req1 = 1'b0; a_in1 = '0; a_in2 = '0; a_out_ready = 1'b1;
      b_req0 = 1'b0; b_req1 = 1'b0; b_in1 = '0; b_in2 = '0; b_out_ready = 1'b1;
      cyc();
      cyc();

      // Reset state.
      check("rst_gnt0",   32'(a_gnt0), 32'd0);
      check("rst_gnt1",   32'(a_gnt1), 32'd0);
      check("rst_select", 32'(a_select), 32'd0);
      check("rst_valid",  32'(a_out_valid), 32'd0);
      check("rst_y",      32'(a_y), 32'd0);
      rst = 1'b0;

      // Single requester stream A0..A5: grant one cycle after request,
      // one beat per cycle, burst counter wraps without losing ownership.
      a_req0 = 1'b1;
      a_in1  = 8'hA0;
      #1;
      check("t2_idle_gnt0", 32'(a_gnt0), 32'd0);
      cyc();
      for (int i = 0; i < 6; i++) begin
         a_in1 = 8'hA0 + 8'(i);
         #1;
         check("t2_gnt0",   32'(a_gnt0), 32'd1);
         check("t2_select", 32'(a_select), 32'd0);
         cyc();
         check("t2_y",      32'(a_y), 32'(8'hA0 + 8'(i)));
         check("t2_valid",  32'(a_out_valid), 32'd1);
      end

      // Reset mid-burst (OWN0, cnt=2, out_valid=1): outputs clear at once.
      rst = 1'b1;
      #1;
      check("t1_valid",  32'(a_out_valid), 32'd0);
      check("t1_y",      32'(a_y), 32'd0);
      check("t1_gnt0",   32'(a_gnt0), 32'd0);
      check("t1_gnt1",   32'(a_gnt1), 32'd0);
      check("t1_select", 32'(a_select), 32'd0);
      a_req0 = 1'b0;
      cyc();
      rst = 1'b0;
      #1;
      check("t1_post_gnt0",  32'(a_gnt0), 32'd0);
      check("t1_post_gnt1",  32'(a_gnt1), 32'd0);
      check("t1_post_valid", 32'(a_out_valid), 32'd0);
      cyc();
      check("t1_idle_gnt0",   32'(a_gnt0), 32'd0);
      check("t1_idle_select", 32'(a_select), 32'd0);

      // Both requesting, MAX_BURST=4: 0,0,0,0,1,1,1,1,0,0 with no idle gap.
      a_req0 = 1'b1; a_req1 = 1'b1;
      a_in1  = 8'h0A; a_in2 = 8'h0B;
      own_seq = 10'b00_1111_0000;
      cyc();
      for (int i = 0; i < 10; i++) begin
         exp_side = own_seq[i];
         #1;
         check("t3_gnt0",   32'(a_gnt0), 32'(!exp_side));
         check("t3_gnt1",   32'(a_gnt1), 32'(exp_side));
         check("t3_select", 32'(a_select), 32'(exp_side));
         cyc();
         check("t3_y", 32'(a_y), exp_side ? 32'h0B : 32'h0A);
      end

      // Stall while owning 0 (cnt=2 -> one beat -> cnt=3, then 3 stalled cycles).
      a_req1 = 1'b0;
      a_in1  = 8'hC0;
      #1;
      check("t4_gnt0_pre", 32'(a_gnt0), 32'd1);
      cyc();
      check("t4_y_pre", 32'(a_y), 32'hC0);
      a_out_ready = 1'b0;
      a_in1 = 8'hC1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_stall_gnt0", 32'(a_gnt0), 32'd0);
         cyc();
         check("t4_stall_y",     32'(a_y), 32'hC0);
         check("t4_stall_valid", 32'(a_out_valid), 32'd1);
      end
      // Resume: held cnt=3 makes this beat the last of the burst; req1 waits.
      a_out_ready = 1'b1;
      a_req1 = 1'b1;
      #1;
      check("t4_resume_gnt0", 32'(a_gnt0), 32'd1);
      cyc();
      check("t4_resume_y", 32'(a_y), 32'hC1);
      a_in2 = 8'hD0;
      #1;
      check("t4_hand_gnt1",   32'(a_gnt1), 32'd1);
      check("t4_hand_gnt0",   32'(a_gnt0), 32'd0);
      check("t4_hand_select", 32'(a_select), 32'd1);
      cyc();
      check("t4_hand_y", 32'(a_y), 32'hD0);

      // Owning 1: second beat, then req1 drops with req0 high.
      a_in2 = 8'hD1;
      #1;
      check("t5_gnt1", 32'(a_gnt1), 32'd1);
      cyc();
      check("t5_y", 32'(a_y), 32'hD1);
      a_req1 = 1'b0;
      cyc();
      check("t5_nobeat_valid", 32'(a_out_valid), 32'd0);
      check("t5_own0_gnt0",    32'(a_gnt0), 32'd1);
      check("t5_own0_select",  32'(a_select), 32'd0);
      a_req0 = 1'b0;
      cyc();
      check("t5_idle_gnt0", 32'(a_gnt0), 32'd0);
      check("t5_idle_gnt1", 32'(a_gnt1), 32'd0);
      a_req0 = 1'b1; a_req1 = 1'b1;
      cyc();
      check("t5_tie_gnt0",   32'(a_gnt0), 32'd1);
      check("t5_tie_gnt1",   32'(a_gnt1), 32'd0);
      check("t5_tie_select", 32'(a_select), 32'd0);
      a_req0 = 1'b0; a_req1 = 1'b0;
      cyc();

      // MAX_BURST=1: strict alternation 11,22,11,22.
      b_req0 = 1'b1; b_req1 = 1'b1;
      b_in1  = 8'h11; b_in2 = 8'h22;
      cyc();
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t6_select", 32'(b_select), 32'(i % 2));
         cyc();
         check("t6_y",     32'(b_y), (i % 2 == 1) ? 32'h22 : 32'h11);
         check("t6_valid", 32'(b_out_valid), 32'd1);
      end
      b_req0 = 1'b0; b_req1 = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_arb_mux_21
